clk_div_gen: RTL and testbench
==============================

# clk_div_gen

Parametrised multi-channel clock/tick divider. It generates NCH independent divided-clock outputs from the single system clock, each with a programmable period and high time, plus a one-cycle period-start tick per channel. Each channel has a run enable and glitch-free reconfiguration: a new setting takes effect only at a period boundary. It sits at the top of the FPGA design and feeds slow clock-enables (sample strobes, LED/scan rates) to downstream logic, replacing fixed /2 and fixed-period dividers.

## Interface
- NCH, 2, number of channels (1..8)
- CNT_W, 12, period counter width per channel
- DIV_DEF, 12'h61A, reset value of every channel's active and pending divisor (period = DIV + 1 cycles)
- HIGH_DEF, 6, reset value of every channel's active and pending high count

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  $clog2(NCH) (min 1)  channel index for the write; indices >= NCH are ignored
- cfg_div  in  CNT_W  divisor: the period is cfg_div+1 cycles
- cfg_high  in  CNT_W  number of high cycles per period
- ch_en  in  NCH  per-channel run enable, level
- sync  in  1  one-cycle strobe that restarts all enabled channels in phase
- clk_out  out  NCH  divided clock, registered
- tick  out  NCH  one-cycle pulse in the first cycle of each period, registered
- pend  out  NCH  a pending configuration is not yet applied

## Operation
- Per channel state: cnt, act_div, act_high, pnd_div, pnd_high, pend flag.
- cfg_we writes pnd_* of channel cfg_ch and sets pend. A later write before the pending values are applied overwrites them (last write wins).
- Apply event: pnd_* is copied to act_* and pend is cleared. It occurs at any of:
  - a wrap (cnt == act_div while enabled),
  - sync while enabled,
  - any cycle while disabled.
- Same-cycle write and apply: the write data bypasses to act_*. In that case pend reads 0 afterwards.
- Counter behaviour:
  - Enabled: cnt counts 0..act_div, then returns to 0.
  - Disabled: cnt is held at 0.
  - sync forces cnt to 0 on enabled channels. sync has priority over the wrap.
- Output rules:
  - clk_out = enabled and (cnt < act_high).
  - act_high = 0 gives a constant low output.
  - act_high > act_div gives a constant high output.
  - act_div = 0 gives a period of 1 cycle; tick is then high every cycle.
- tick = enabled and cnt == 0.
- Enable and disable:
  - Rising ch_en: the channel starts at cnt = 0 on the next edge, with tick and the first high cycle.
  - Falling ch_en: clk_out and tick go low on the next edge. No partial-period completion is required.

## Timing
- Reset (rst = 0 at an edge) sets:
  - cnt = 0, clk_out = 0, tick = 0, pend = 0,
  - act_* = pnd_* = DIV_DEF / HIGH_DEF.
- Reset mid-period aborts the current period immediately.
- Outputs change only on clk edges, with no combinational path from inputs. Latency from ch_en or sync to the first tick is exactly 1 cycle.
- Write at cycle t:
  - Channel disabled: new values are active at t+1.
  - Channel enabled: the first cycle using new values is the cycle after the next wrap (or sync).
- Width rule: all compares are unsigned on CNT_W bits. No arithmetic beyond cnt+1, which never overflows because cnt ≤ act_div.

## Structure
- Package clk_div_pkg holds:
  - CNT_W_DEF, DIV_DEF, HIGH_DEF,
  - a channel-config struct type {div, high}.
- Sub-module clk_div_ch contains one channel: the counter, the active/pending registers, and the output flops. clk_div_gen instantiates it NCH times via generate and decodes cfg_we/cfg_ch into per-channel write strobes.

## Test plan
- Reset defaults:
  - Stimulus: rst low 3 cycles, then ch_en = 1 on channel 0.
  - Response: tick every 1563 cycles; clk_out high for exactly 6 cycles after each tick; pend = 0.
- Divide-by-2:
  - Stimulus: on disabled channel 1, write div = 1, high = 1; then enable.
  - Response: clk_out toggles every cycle with 50% duty; tick on every other cycle.
- Glitch-free reconfiguration:
  - Stimulus: channel 0 running div = 9, high = 5; write div = 3, high = 2 mid-period (cnt = 4).
  - Response: the current 10-cycle period completes unchanged; pend = 1 until the wrap; the next period is 4 cycles with 2 high.
- Boundary values:
  - high = 0 gives clk_out constant 0 with ticks still present.
  - high = 20 with div = 9 gives clk_out constant 1.
  - div = 0 gives tick = 1 every cycle.
- sync and same-cycle write:
  - Stimulus: two channels at div = 7 with phases offset by 3; pulse sync together with cfg_we to channel 0 (div = 5).
  - Response: both ticks on the next cycle; channel 0 immediately has a 6-cycle period; pend[0] = 0.
- Disable and mid-operation reset:
  - Stimulus: drop ch_en at cnt = 2.
  - Response: outputs low next cycle; re-enable gives tick after 1 cycle.
  - Stimulus: rst low during a period.
  - Response: all outputs 0 next cycle; active settings are the defaults.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock/tick divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_div_pkg;

    // Default period-counter width per channel
    localparam int CNT_W_DEF = 12;

    // Power-up divisor: period = DIV_DEF + 1 = 1563 cycles
    localparam int DIV_DEF = 'h61A;

    // Power-up high count per period
    localparam int HIGH_DEF = 6;

    // One channel's configuration at the default counter width. Modules
    // built with a different CNT_W declare the same {div, high} layout
    // locally at their own width.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;
        logic [CNT_W_DEF-1:0] high;
    } ch_cfg_t;

    // Width of a channel index; a single channel still gets a 1-bit index.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active/pending config, registered outputs.
// Latency: outputs are registered, 1 cycle from en/sync/config to effect.
// Backpressure: none; config writes always accepted, applied only at a period boundary.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DIV_RST  = DIV_DEF,
    parameter int HIGH_RST = HIGH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    input  logic             en,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
    } cfg_t;

    localparam cfg_t CFG_RST = '{div: CNT_W'(DIV_RST), high: CNT_W'(HIGH_RST)};

    // cnt_q is the position of the cycle currently being presented on the
    // outputs; run_q says whether that cycle belonged to an enabled period.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             run_q;
    cfg_t             act_q;
    cfg_t             pnd_q;
    cfg_t             act_nxt;
    cfg_t             pnd_nxt;
    logic             pend_q;
    logic             pend_nxt;
    logic             wrap;
    logic             restart;
    logic             apply;

    // Decide whether the next cycle starts a new period and what config it uses
    always_comb begin
        wrap    = run_q && (cnt_q == act_q.div);
        // A period starts on wrap, on sync, or on the first enabled cycle
        restart = en && (sync || !run_q || wrap);
        // While disabled the channel has no period to protect, so apply freely
        apply   = !en || restart;

        pnd_nxt = pnd_q;
        if (wr_en) begin
            pnd_nxt = '{div: wr_div, high: wr_high};
        end

        // Taking pnd_nxt (not pnd_q) lets a same-cycle write bypass to active
        act_nxt  = apply ? pnd_nxt : act_q;
        pend_nxt = apply ? 1'b0 : (pend_q || wr_en);

        // cnt never exceeds act_div, so the increment cannot overflow
        cnt_nxt = apply ? '0 : cnt_q + CNT_W'(1);
    end

    // State and output flops; outputs are derived from next-state so they
    // line up with the cycle the counter describes
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            run_q   <= 1'b0;
            act_q   <= CFG_RST;
            pnd_q   <= CFG_RST;
            pend_q  <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            run_q   <= en;
            act_q   <= act_nxt;
            pnd_q   <= pnd_nxt;
            pend_q  <= pend_nxt;
            clk_out <= en && (cnt_nxt < act_nxt.high);
            tick    <= en && (cnt_nxt == '0);
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// NCH-channel programmable clock/tick divider with glitch-free reconfiguration.
// Latency: 1 cycle from ch_en/sync to first tick; outputs fully registered.
// Backpressure: none; config writes to indices >= NCH are dropped.
module clk_div_gen #(
    parameter int NCH      = 2,
    parameter int CNT_W    = clk_div_pkg::CNT_W_DEF,
    parameter int DIV_DEF  = clk_div_pkg::DIV_DEF,
    parameter int HIGH_DEF = clk_div_pkg::HIGH_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_we,
    input  logic [clk_div_pkg::ch_idx_w(NCH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                      cfg_div,
    input  logic [CNT_W-1:0]                      cfg_high,
    input  logic [NCH-1:0]                        ch_en,
    input  logic                                  sync,
    output logic [NCH-1:0]                        clk_out,
    output logic [NCH-1:0]                        tick,
    output logic [NCH-1:0]                        pend
);

    localparam int CH_W = clk_div_pkg::ch_idx_w(NCH);

    logic [NCH-1:0] ch_we;

    // Decode the shared write strobe into per-channel strobes; an index with
    // no matching channel simply selects nothing
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DIV_RST  (DIV_DEF),
            .HIGH_RST (HIGH_DEF)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (ch_we[g]),
            .wr_div  (cfg_div),
            .wr_high (cfg_high),
            .en      (ch_en[g]),
            .sync    (sync),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pend    (pend[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

    localparam int NCH    = 2;
    localparam int CNT_W  = 12;
    localparam int DEF_PERIOD = 'h61A + 1;
    localparam int DEF_HIGH   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [0:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic [NCH-1:0]   ch_en;
    logic             sync;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pend;

    clk_div_gen #(
        .NCH      (NCH),
        .CNT_W    (CNT_W),
        .DIV_DEF  ('h61A),
        .HIGH_DEF (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .ch_en    (ch_en),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             we;
        logic             ch;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
        logic [NCH-1:0]   en;
        logic             sync;
        logic [NCH-1:0]   e_clk;
        logic [NCH-1:0]   e_tick;
        logic [NCH-1:0]   e_pend;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: clk/tick/pend got %b_%b_%b want %b_%b_%b", name,
                      got[5:4], got[3:2], got[1:0], want[5:4], want[3:2], want[1:0]);
    endtask

    task automatic row(input logic we, input logic ch, input int div, input int high,
                       input logic [1:0] en, input logic sy,
                       input logic [1:0] ec, input logic [1:0] et, input logic [1:0] ep);
        vec_t v;
        v.rst = 1'b1; v.we = we; v.ch = ch; v.div = CNT_W'(div); v.high = CNT_W'(high);
        v.en = en; v.sync = sy; v.e_clk = ec; v.e_tick = et; v.e_pend = ep;
        vq.push_back(v);
    endtask

    task automatic idle(input logic [1:0] en, input logic [1:0] ec, input logic [1:0] et,
                        input logic [1:0] ep);
        row(1'b0, 1'b0, 0, 0, en, 1'b0, ec, et, ep);
    endtask

    // ch0 enabled with reset defaults; first edge is period position 0
    task automatic run_default(input string name, input int cycles);
        logic [5:0] want;
        ch_en = 2'b01; rst = 1'b1; cfg_we = 1'b0; sync = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            want = {1'b0, (k % DEF_PERIOD) < DEF_HIGH, 1'b0, (k % DEF_PERIOD) == 0, 2'b00};
            check(name, {clk_out, tick, pend}, want);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
        ch_en = '0; sync = 1'b0;

        // Reset held for 3 cycles: everything low
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("reset", {clk_out, tick, pend}, 6'b0);
        end

        // Defaults: 1563-cycle period, 6 high cycles, ticks at 0, 1563, 3126
        run_default("default_run", 2 * DEF_PERIOD + 2);

        // ---------------- vector table ----------------
        v = '{rst: 1'b0, we: 1'b0, ch: 1'b0, div: '0, high: '0, en: 2'b00, sync: 1'b0,
              e_clk: 2'b00, e_tick: 2'b00, e_pend: 2'b00};
        vq.push_back(v);

        // Divide-by-2 on disabled ch1: write applies immediately, then enable
        row(1, 1, 1, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 5; k++)
            idle(2'b10, (k % 2 == 0) ? 2'b10 : 2'b00, (k % 2 == 0) ? 2'b10 : 2'b00, 2'b00);

        // Glitch-free reconfiguration on ch0: div 9/high 5, rewrite at cnt 4
        row(1, 0, 9, 5, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 5; k++) idle(2'b01, 2'b01, (k == 0) ? 2'b01 : 2'b00, 2'b00);
        row(1, 0, 3, 2, 2'b01, 0, 2'b00, 2'b00, 2'b01);
        for (int k = 6; k < 10; k++) idle(2'b01, 2'b00, 2'b00, 2'b01);
        for (int k = 0; k < 6; k++)
            idle(2'b01, ((k % 4) < 2) ? 2'b01 : 2'b00, ((k % 4) == 0) ? 2'b01 : 2'b00, 2'b00);

        // high = 0: constant low, ticks every 4 cycles
        row(1, 0, 3, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 5; k++) idle(2'b01, 2'b00, ((k % 4) == 0) ? 2'b01 : 2'b00, 2'b00);

        // high = 20 > div = 9: constant high
        row(1, 0, 9, 20, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 11; k++) idle(2'b01, 2'b01, ((k % 10) == 0) ? 2'b01 : 2'b00, 2'b00);

        // div = 0: tick every cycle
        row(1, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++) idle(2'b01, 2'b01, 2'b01, 2'b00);

        // sync with same-cycle write: both channels div 7, ch1 lags ch0 by 3
        row(1, 0, 7, 4, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        row(1, 1, 7, 4, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        idle(2'b01, 2'b01, 2'b01, 2'b00);
        idle(2'b01, 2'b01, 2'b00, 2'b00);
        idle(2'b01, 2'b01, 2'b00, 2'b00);
        idle(2'b11, 2'b11, 2'b10, 2'b00);
        idle(2'b11, 2'b10, 2'b00, 2'b00);
        row(1, 0, 5, 2, 2'b11, 1, 2'b11, 2'b11, 2'b00);
        idle(2'b11, 2'b11, 2'b00, 2'b00);
        idle(2'b11, 2'b10, 2'b00, 2'b00);
        idle(2'b11, 2'b10, 2'b00, 2'b00);
        idle(2'b11, 2'b00, 2'b00, 2'b00);
        idle(2'b11, 2'b00, 2'b00, 2'b00);
        idle(2'b11, 2'b01, 2'b01, 2'b00);
        idle(2'b11, 2'b01, 2'b00, 2'b00);
        idle(2'b11, 2'b10, 2'b10, 2'b00);

        // Drop ch0 at cnt 2, re-enable: tick one cycle later
        idle(2'b10, 2'b10, 2'b00, 2'b00);
        idle(2'b11, 2'b11, 2'b01, 2'b00);

        // Two writes to running ch1 before its wrap: the second one wins
        row(1, 1, 3, 3, 2'b11, 0, 2'b11, 2'b00, 2'b10);
        row(1, 1, 1, 1, 2'b11, 0, 2'b00, 2'b00, 2'b10);
        idle(2'b11, 2'b00, 2'b00, 2'b10);
        idle(2'b11, 2'b00, 2'b00, 2'b10);
        idle(2'b11, 2'b00, 2'b00, 2'b10);
        idle(2'b11, 2'b11, 2'b11, 2'b00);
        idle(2'b11, 2'b01, 2'b00, 2'b00);
        idle(2'b11, 2'b10, 2'b10, 2'b00);

        foreach (vq[i]) begin
            rst = vq[i].rst; cfg_we = vq[i].we; cfg_ch = vq[i].ch;
            cfg_div = vq[i].div; cfg_high = vq[i].high;
            ch_en = vq[i].en; sync = vq[i].sync;
            @(posedge clk); #1;
            check($sformatf("vec[%0d]", i), {clk_out, tick, pend},
                  {vq[i].e_clk, vq[i].e_tick, vq[i].e_pend});
        end

        // Reset mid-period with both channels running, then defaults return
        cfg_we = 1'b0; sync = 1'b0; ch_en = 2'b11; rst = 1'b0;
        @(posedge clk); #1;
        check("mid_reset", {clk_out, tick, pend}, 6'b0);
        run_default("post_reset_run", DEF_PERIOD + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
